// File: rtl/tx_fifo_osr.sv
// Transmit path: a DEPTH-entry host FIFO draining into a 32-bit output shift register that
// serves state-machine PULL and OUT requests, with optional autopull and a stall handshake.
module tx_fifo_osr #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   push_valid,
    output logic                   push_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    input  logic                   pull_req,
    input  logic                   pull_block,
    input  logic [DATA_W-1:0]      x_in,
    input  logic                   out_req,
    input  logic [4:0]             out_count,
    input  logic                   shift_right,
    input  logic                   autopull_en,
    input  logic [4:0]             pull_thresh,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    output logic                   pull_done,
    output logic [5:0]             osr_count,
    output logic                   stall
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PULL_WAIT = 2'd1,
        ST_OUT_WAIT  = 2'd2
    } state_t;

    // Bit-count update after an OUT; the count never exceeds a full register.
    function automatic logic [5:0] sat_add32(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > 7'd32) begin
            sat_add32 = 6'd32;
        end else begin
            sat_add32 = sum[5:0];
        end
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DATA_W-1:0] osr_r;
    logic [DATA_W-1:0] osr_nxt_s;
    logic [5:0]        osr_count_r;
    logic [5:0]        osr_count_nxt_s;
    logic [DATA_W-1:0] out_data_r;
    logic [DATA_W-1:0] out_data_nxt_s;
    logic              out_valid_r;
    logic              out_valid_nxt_s;
    logic              pull_done_r;
    logic              pull_done_nxt_s;
    logic              stall_s;

    logic              empty_s;
    logic              push_fire_s;
    logic              pop_s;
    logic [DATA_W-1:0] head_s;
    logic [5:0]        n_s;
    logic [5:0]        thresh_s;
    logic              at_thresh_s;
    logic [DATA_W-1:0] shr_data_s;
    logic [DATA_W-1:0] shl_data_s;

    assign empty_s     = (level_r == LW'(0));
    assign push_ready  = (level_r != LW'(DEPTH));
    assign push_fire_s = push_valid & push_ready;
    assign head_s      = mem_r[rd_ptr_r];

    // Encodings of 0 mean a full 32-bit register.
    assign n_s         = (out_count == 5'd0) ? 6'd32 : {1'b0, out_count};
    assign thresh_s    = (pull_thresh == 5'd0) ? 6'd32 : {1'b0, pull_thresh};
    assign at_thresh_s = (osr_count_r >= thresh_s);

    assign shr_data_s  = osr_r & ~({DATA_W{1'b1}} << n_s);
    assign shl_data_s  = osr_r >> (6'd32 - n_s);

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LW'(0);
        end else begin
            if (push_fire_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_fire_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Request sequencing: PULL, OUT, autopull and the stall decision
    always_comb begin
        state_nxt_s     = state_r;
        pop_s           = 1'b0;
        osr_nxt_s       = osr_r;
        osr_count_nxt_s = osr_count_r;
        out_data_nxt_s  = {DATA_W{1'b0}};
        out_valid_nxt_s = 1'b0;
        pull_done_nxt_s = 1'b0;
        stall_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pull_req) begin
                    if (!empty_s) begin
                        pop_s           = 1'b1;
                        osr_nxt_s       = head_s;
                        osr_count_nxt_s = 6'd0;
                        pull_done_nxt_s = 1'b1;
                    end else if (!pull_block) begin
                        osr_nxt_s       = x_in;
                        osr_count_nxt_s = 6'd0;
                        pull_done_nxt_s = 1'b1;
                    end else begin
                        stall_s     = 1'b1;
                        state_nxt_s = ST_PULL_WAIT;
                    end
                end else if (out_req) begin
                    if (autopull_en && at_thresh_s) begin
                        // Refill first; the OUT itself runs once the count is back under threshold.
                        stall_s = 1'b1;
                        if (!empty_s) begin
                            pop_s           = 1'b1;
                            osr_nxt_s       = head_s;
                            osr_count_nxt_s = 6'd0;
                        end else begin
                            state_nxt_s = ST_OUT_WAIT;
                        end
                    end else begin
                        out_valid_nxt_s = 1'b1;
                        osr_count_nxt_s = sat_add32(osr_count_r, n_s);
                        if (shift_right) begin
                            out_data_nxt_s = shr_data_s;
                            osr_nxt_s      = osr_r >> n_s;
                        end else begin
                            out_data_nxt_s = shl_data_s;
                            osr_nxt_s      = osr_r << n_s;
                        end
                    end
                end else if (autopull_en && at_thresh_s && !empty_s) begin
                    pop_s           = 1'b1;
                    osr_nxt_s       = head_s;
                    osr_count_nxt_s = 6'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PULL_WAIT: begin
                if (!empty_s) begin
                    pop_s           = 1'b1;
                    osr_nxt_s       = head_s;
                    osr_count_nxt_s = 6'd0;
                    pull_done_nxt_s = 1'b1;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            ST_OUT_WAIT: begin
                stall_s = 1'b1;
                if (!empty_s) begin
                    pop_s           = 1'b1;
                    osr_nxt_s       = head_s;
                    osr_count_nxt_s = 6'd0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OUT_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, shift register and registered result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            osr_r       <= {DATA_W{1'b0}};
            osr_count_r <= 6'd32;
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            pull_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            osr_r       <= osr_nxt_s;
            osr_count_r <= osr_count_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            pull_done_r <= pull_done_nxt_s;
        end
    end

    // Stall is masked during reset so a held request cannot leak through.
    assign stall      = stall_s & rst;
    assign fifo_level = level_r;
    assign osr_count  = osr_count_r;
    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign pull_done  = pull_done_r;

endmodule

// File: tb/tb_tx_fifo_osr.sv
// Scoreboard bench for tx_fifo_osr: OUT results are queued when issued and checked when
// out_valid fires; FIFO, PULL, autopull, stall and reset behaviour are checked inline.
module tb_tx_fifo_osr;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] push_data;
    logic        push_valid;
    logic        push_ready;
    logic [2:0]  fifo_level;
    logic        pull_req;
    logic        pull_block;
    logic [31:0] x_in;
    logic        out_req;
    logic [4:0]  out_count;
    logic        shift_right;
    logic        autopull_en;
    logic [4:0]  pull_thresh;
    logic [31:0] out_data;
    logic        out_valid;
    logic        pull_done;
    logic [5:0]  osr_count;
    logic        stall;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    tx_fifo_osr #(.DEPTH(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .push_data(push_data), .push_valid(push_valid), .push_ready(push_ready),
        .fifo_level(fifo_level),
        .pull_req(pull_req), .pull_block(pull_block), .x_in(x_in),
        .out_req(out_req), .out_count(out_count), .shift_right(shift_right),
        .autopull_en(autopull_en), .pull_thresh(pull_thresh),
        .out_data(out_data), .out_valid(out_valid), .pull_done(pull_done),
        .osr_count(osr_count), .stall(stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] d);
        push_valid = 1'b1;
        push_data  = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic do_pull_nb(input logic [31:0] x);
        pull_req   = 1'b1;
        pull_block = 1'b0;
        x_in       = x;
        #1;
        chk("pull_stall", stall, 1'b0);
        tick();
        pull_req = 1'b0;
        chk("pull_done", pull_done, 1'b1);
        chk("pull_osr_count", osr_count, 6'd0);
    endtask

    task automatic do_out(input logic [4:0] n, input logic right, input logic [31:0] exp);
        out_req     = 1'b1;
        out_count   = n;
        shift_right = right;
        sb_q.push_back(exp);
        #1;
        chk("out_stall", stall, 1'b0);
        tick();
        out_req = 1'b0;
    endtask

    // Scoreboard: every out_valid pulse must match the oldest issued OUT.
    always @(negedge clk) begin
        if (out_valid) begin
            chk("sb_nonempty", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
                chk("out_data", out_data, sb_q.pop_front());
            end
        end
    end

    logic [31:0] drain_words [5] = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003,
                                     32'hA5A5_0004, 32'hA5A5_0006};
    logic [2:0]  drain_levels [5] = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};

    initial begin
        rst = 1'b0; push_data = 32'd0; push_valid = 1'b0; pull_req = 1'b0; pull_block = 1'b0;
        x_in = 32'd0; out_req = 1'b0; out_count = 5'd0; shift_right = 1'b1;
        autopull_en = 1'b0; pull_thresh = 5'd0;
        #12;
        chk("rst_push_ready", push_ready, 1'b1);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_pull_done", pull_done, 1'b0);
        chk("rst_osr_count", osr_count, 6'd32);
        chk("rst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Fill to full; the fifth word must be refused.
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1;
            push_data  = 32'hA5A5_0001 + 32'(i);
            #1;
            chk("fill_push_ready", push_ready, 1'b1);
            tick();
        end
        push_data = 32'hA5A5_0005;
        #1;
        chk("full_push_ready", push_ready, 1'b0);
        chk("full_level", fifo_level, 3'd4);
        tick();
        push_valid = 1'b0;
        chk("full_level_hold", fifo_level, 3'd4);

        // Drain in order; a push alongside the pop at full is refused, one at level 3 is kept.
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                push_valid = 1'b1; push_data = 32'hA5A5_0005;
            end else if (i == 1) begin
                push_valid = 1'b1; push_data = 32'hA5A5_0006;
            end else begin
                push_valid = 1'b0;
            end
            do_pull_nb(32'hFFFF_FFFF);
            push_valid = 1'b0;
            chk("drain_level", fifo_level, drain_levels[i]);
            do_out(5'd0, 1'b1, drain_words[i]);
        end

        // Blocking PULL on empty waits for a push.
        pull_req = 1'b1; pull_block = 1'b1;
        #1;
        chk("bpull_stall_seen", stall, 1'b1);
        tick();
        chk("bpull_stall_wait", stall, 1'b1);
        push_valid = 1'b1; push_data = 32'hDEAD_BEEF;
        #1;
        chk("bpull_stall_push", stall, 1'b1);
        tick();
        push_valid = 1'b0;
        chk("bpull_stall_release", stall, 1'b0);
        chk("bpull_no_done_yet", pull_done, 1'b0);
        tick();
        pull_req = 1'b0;
        chk("bpull_done", pull_done, 1'b1);
        chk("bpull_level", fifo_level, 3'd0);
        do_out(5'd0, 1'b1, 32'hDEAD_BEEF);

        // Non-blocking PULL on empty loads x_in.
        do_pull_nb(32'h1234_5678);
        do_out(5'd0, 1'b1, 32'h1234_5678);

        // Shift directions, saturation and empty-OSR OUT.
        do_pull_nb(32'hF000_000F);
        do_out(5'd4, 1'b1, 32'h0000_000F);
        do_out(5'd4, 1'b0, 32'h0000_0000);
        chk("osr_count_8", osr_count, 6'd8);
        do_out(5'd0, 1'b1, 32'hF000_0000);
        chk("osr_count_sat", osr_count, 6'd32);
        do_out(5'd8, 1'b1, 32'h0000_0000);
        chk("osr_count_empty", osr_count, 6'd32);
        do_pull_nb(32'hF000_000F);
        do_out(5'd4, 1'b0, 32'h0000_000F);
        do_out(5'd0, 1'b0, 32'h0000_00F0);

        // Autopull at threshold 8.
        autopull_en = 1'b1; pull_thresh = 5'd8;
        do_pull_nb(32'h0000_0021);
        do_push(32'h0000_00AB);
        chk("ap_level_pre", fifo_level, 3'd1);
        do_out(5'd4, 1'b1, 32'h0000_0001);
        do_out(5'd4, 1'b1, 32'h0000_0002);
        tick();
        chk("ap_level_post", fifo_level, 3'd0);
        chk("ap_osr_count", osr_count, 6'd0);
        chk("ap_no_pull_done", pull_done, 1'b0);
        do_out(5'd4, 1'b1, 32'h0000_000B);
        do_out(5'd4, 1'b1, 32'h0000_000A);
        out_req = 1'b1; out_count = 5'd4; shift_right = 1'b1;
        sb_q.push_back(32'h0000_000D);
        #1;
        chk("ap_stall_seen", stall, 1'b1);
        tick();
        chk("ap_stall_wait", stall, 1'b1);
        push_valid = 1'b1; push_data = 32'h0000_00CD;
        #1;
        chk("ap_stall_push", stall, 1'b1);
        tick();
        push_valid = 1'b0;
        chk("ap_stall_refill", stall, 1'b1);
        tick();
        chk("ap_stall_release", stall, 1'b0);
        tick();
        out_req = 1'b0;
        chk("ap_osr_count_after", osr_count, 6'd4);
        autopull_en = 1'b0;

        // Reset while stalled in a blocking PULL.
        pull_req = 1'b1; pull_block = 1'b1;
        #1;
        chk("rs_stall_seen", stall, 1'b1);
        tick();
        chk("rs_stall_wait", stall, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("rs_stall", stall, 1'b0);
        chk("rs_level", fifo_level, 3'd0);
        chk("rs_push_ready", push_ready, 1'b1);
        chk("rs_osr_count", osr_count, 6'd32);
        pull_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rs_idle_stall", stall, 1'b0);
        chk("rs_idle_pull_done", pull_done, 1'b0);
        do_pull_nb(32'hCAFE_F00D);
        do_out(5'd16, 1'b0, 32'h0000_CAFE);

        tick();
        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
